// File: rtl/reverb_config_loader.sv
// -----------------------------------------------------------------------------
// reverb_config_loader
//
// Receives a framed byte stream that carries a complete reverberator
// configuration. Each frame holds six delay words and seven gain words. The
// frame is collected into a shadow buffer and then verified: first the XOR
// checksum, then the range of every word. The live outputs are updated only
// when a frame passes both checks, and all of them change on the same edge.
// A write strobe follows one cycle after that update, so the reverberator
// always latches a consistent set of values.
//
// Frame: 0xA5 header, then 13 words (tau0..tau5, gain0..gain6) of
//        B = ceil(W/8) bytes each, least significant byte first, then one
//        checksum byte equal to the XOR of all payload bytes.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   in_valid      byte stream valid
//   in_data[7:0]  byte stream data
//   in_ready      byte accepted when in_valid && in_ready (decoded from state)
//   tau[6]        committed delay words (signed, W bits)
//   gain[7]       committed gain words (signed, W bits)
//   write         config-update strobe, high for WRITE_HOLD cycles
//   busy          high whenever the loader is not idle
//   err_checksum  sticky: last rejected frame had a bad checksum
//   err_range     sticky: last rejected frame had an out-of-range word
//   frames_ok     count of committed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 2048
`endif

module reverb_config_loader #(
  parameter int WIDTH      = 24,
  parameter int FRAC       = `FIXED_POINT,
  parameter int MAXDELAY   = `MAX_FILTER_FIFO_LENGTH,
  parameter int TIMEOUT    = 1024,
  parameter int WRITE_HOLD = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic signed [WIDTH+FRAC-1:0]   tau  [6],
  output logic signed [WIDTH+FRAC-1:0]   gain [7],
  output logic                           write,
  output logic                           busy,
  output logic                           err_checksum,
  output logic                           err_range,
  output logic [7:0]                     frames_ok
);

  localparam int W      = WIDTH + FRAC;
  localparam int B      = (W + 7) / 8;
  localparam int NWORDS = 13;
  localparam int NBYTES = NWORDS * B;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int TCW    = $clog2(TIMEOUT + 1);
  localparam int HCW    = $clog2(WRITE_HOLD + 1);

  localparam logic [7:0] HEADER = 8'hA5;

  // Legal ranges, held as signed W-bit values so that a word with its top
  // bit set compares as negative and is rejected.
  localparam logic signed [W-1:0] TAU_MIN  = W'(1);
  localparam logic signed [W-1:0] TAU_MAX  = W'(MAXDELAY - 1);
  localparam logic signed [W-1:0] GAIN_MIN = W'(0);
  localparam logic signed [W-1:0] GAIN_MAX = W'(2 ** FRAC);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    COMMIT,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [BCW-1:0]        byte_cnt;
  logic [TCW-1:0]        idle_cnt;
  logic [HCW-1:0]        hold_cnt;
  logic [7:0]            run_xor;
  logic                  csum_bad;
  logic [7:0]            shadow [NBYTES];
  logic signed [W-1:0]   words  [NWORDS];
  logic                  range_bad;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Reassemble the little-endian shadow bytes into W-bit words. Bits above W
  // in the last byte of each word are dropped.
  // ---------------------------------------------------------------------------
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    logic [8*B-1:0] raw;
    for (genvar b = 0; b < B; b++) begin : g_byte
      assign raw[8*b +: 8] = shadow[w*B + b];
    end
    assign words[w] = raw[W-1:0];
  end

  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (words[i] < TAU_MIN || words[i] > TAU_MAX) range_bad = 1'b1;
    end
    for (int i = 0; i < 7; i++) begin
      if (words[6+i] < GAIN_MIN || words[6+i] > GAIN_MAX) range_bad = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept && in_data == HEADER) state_nxt = PAYLOAD;
      end

      PAYLOAD: begin
        in_ready = 1'b1;
        if (accept) begin
          // The byte following the last payload byte is the checksum.
          if (byte_cnt == BCW'(NBYTES)) state_nxt = CHECK;
        end else if (idle_cnt == TCW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abandon the frame.
          state_nxt = IDLE;
        end
      end

      CHECK: begin
        state_nxt = (csum_bad || range_bad) ? IDLE : COMMIT;
      end

      COMMIT: begin
        state_nxt = HOLD;
      end

      HOLD: begin
        if (hold_cnt == HCW'(WRITE_HOLD)) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      hold_cnt     <= '0;
      run_xor      <= '0;
      csum_bad     <= 1'b0;
      write        <= 1'b0;
      err_checksum <= 1'b0;
      err_range    <= 1'b0;
      frames_ok    <= '0;
      // NOTE: the shadow array is small and register-based, so it is cleared
      // on reset like any other state; a RAM-backed store would not be.
      for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
      for (int i = 0; i < 6; i++) tau[i] <= TAU_MIN;
      for (int i = 0; i < 7; i++) gain[i] <= GAIN_MIN;
    end else begin
      state <= state_nxt;

      case (state)
        IDLE: begin
          if (accept && in_data == HEADER) begin
            byte_cnt <= '0;
            run_xor  <= '0;
            idle_cnt <= '0;
          end
        end

        PAYLOAD: begin
          if (accept) begin
            idle_cnt <= '0;
            if (byte_cnt == BCW'(NBYTES)) begin
              csum_bad <= (in_data != run_xor);
            end else begin
              shadow[byte_cnt] <= in_data;
              run_xor          <= run_xor ^ in_data;
              byte_cnt         <= byte_cnt + BCW'(1);
            end
          end else begin
            idle_cnt <= idle_cnt + TCW'(1);
          end
        end

        CHECK: begin
          // Checksum failure wins; exactly one flag describes the rejection.
          if (csum_bad) begin
            err_checksum <= 1'b1;
            err_range    <= 1'b0;
          end else if (range_bad) begin
            err_checksum <= 1'b0;
            err_range    <= 1'b1;
          end
        end

        COMMIT: begin
          for (int i = 0; i < 6; i++) tau[i] <= words[i];
          for (int i = 0; i < 7; i++) gain[i] <= words[6+i];
          frames_ok    <= frames_ok + 8'd1;
          err_checksum <= 1'b0;
          err_range    <= 1'b0;
          hold_cnt     <= '0;
        end

        HOLD: begin
          // The first HOLD cycle keeps write low, so the strobe rises one
          // cycle after the outputs changed and then lasts WRITE_HOLD cycles.
          if (hold_cnt != HCW'(WRITE_HOLD)) begin
            write    <= 1'b1;
            hold_cnt <= hold_cnt + HCW'(1);
          end else begin
            write <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_reverb_config_loader
//
// Directed bench for reverb_config_loader with its default parameters
// (W = 32, B = 4, FRAC = 8, MAXDELAY = 2048, TIMEOUT = 1024, WRITE_HOLD = 4).
// Frames are built from word tables, and the bench computes the checksum
// itself. A small model keeps the last committed outputs and the frame count.
// -----------------------------------------------------------------------------

module tb_reverb_config_loader;

  localparam int TIMEOUT_C = 1024;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic signed [31:0] tau  [6];
  logic signed [31:0] gain [7];
  logic               write;
  logic               busy;
  logic               err_checksum;
  logic               err_range;
  logic [7:0]         frames_ok;

  reverb_config_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .tau          (tau),
    .gain         (gain),
    .write        (write),
    .busy         (busy),
    .err_checksum (err_checksum),
    .err_range    (err_range),
    .frames_ok    (frames_ok)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fw      [13];
  logic [31:0] exp_tau [6];
  logic [31:0] exp_gain[7];
  logic [7:0]  exp_frames;

  int          rj_idx [3] = '{5, 12, 0};
  logic [31:0] rj_val [3] = '{32'd2048, 32'hFFFF_FFFF, 32'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 6; i++) exp_tau[i] = 32'd1;
    for (int i = 0; i < 7; i++) exp_gain[i] = 32'd0;
    exp_frames = 8'd0;
  endtask

  task automatic commit_expect();
    for (int i = 0; i < 6; i++) exp_tau[i] = fw[i];
    for (int i = 0; i < 7; i++) exp_gain[i] = fw[6+i];
    exp_frames = exp_frames + 8'd1;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 6; i++) check($sformatf("%s_tau%0d", tag, i), tau[i], exp_tau[i]);
    for (int i = 0; i < 7; i++) check($sformatf("%s_gain%0d", tag, i), gain[i], exp_gain[i]);
  endtask

  // Present one byte and hold it until accepted; returns just after the
  // accepting edge. Optional random idle gaps precede the byte.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    bit done;
    done = 1'b0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 64 && !done; t++) begin
      acc = in_ready;
      tick();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("byte_accepted", done, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] csum_flip, input bit gaps);
    logic [7:0] x;
    logic [7:0] by;
    x = 8'h00;
    send_byte(8'hA5, gaps);
    for (int w = 0; w < 13; w++) begin
      for (int b = 0; b < 4; b++) begin
        by = fw[w][8*b +: 8];
        x  = x ^ by;
        send_byte(by, gaps);
      end
    end
    send_byte(x ^ csum_flip, gaps);
  endtask

  task automatic set_v1();
    fw = '{32'd1557, 32'd1617, 32'd1491, 32'd1422, 32'd225, 32'd556,
           32'hB3, 32'hB3, 32'hB3, 32'hB3, 32'hB3, 32'hB3, 32'hB3};
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_write;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset_model();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_err_cs", err_checksum, 1'b0);
    check("rst_err_rg", err_range, 1'b0);
    check("rst_frames", frames_ok, 8'd0);
    check_outputs("rst");

    // V2: corrupted checksum
    set_v1();
    send_frame(8'h01, 1'b0);
    check("v2_busy_check", busy, 1'b1);
    check("v2_ready_check", in_ready, 1'b0);
    saw_write = 1'b0;
    repeat (8) begin
      tick();
      if (write) saw_write = 1'b1;
    end
    check("v2_no_write", saw_write, 1'b0);
    check("v2_err_cs", err_checksum, 1'b1);
    check("v2_err_rg", err_range, 1'b0);
    check("v2_frames", frames_ok, 8'd0);
    check("v2_busy", busy, 1'b0);
    check_outputs("v2");

    // V3: gain2 above 1.0 with a valid checksum
    set_v1();
    fw[8] = 32'h101;
    send_frame(8'h00, 1'b0);
    repeat (4) tick();
    check("v3_err_rg", err_range, 1'b1);
    check("v3_err_cs", err_checksum, 1'b0);
    check("v3_frames", frames_ok, 8'd0);
    check_outputs("v3");

    // Further range rejects: tau at MAXDELAY, negative gain, tau of zero
    for (int r = 0; r < 3; r++) begin
      set_v1();
      fw[rj_idx[r]] = rj_val[r];
      send_frame(8'h00, 1'b0);
      repeat (4) tick();
      check($sformatf("rj%0d_err_rg", r), err_range, 1'b1);
      check($sformatf("rj%0d_err_cs", r), err_checksum, 1'b0);
      check($sformatf("rj%0d_frames", r), frames_ok, 8'd0);
    end
    check_outputs("rj");

    // V1: valid frame with exact latency
    set_v1();
    send_frame(8'h00, 1'b0);
    check("v1_n_tau0", tau[0], 32'd1);
    check("v1_n_write", write, 1'b0);
    tick();
    check("v1_n1_tau0", tau[0], 32'd1);
    check("v1_n1_write", write, 1'b0);
    check("v1_n1_ready", in_ready, 1'b0);
    tick();
    commit_expect();
    check_outputs("v1_n2");
    check("v1_n2_write", write, 1'b0);
    check("v1_n2_frames", frames_ok, 8'd1);
    check("v1_n2_err_cs", err_checksum, 1'b0);
    check("v1_n2_err_rg", err_range, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("v1_write_n%0d", k + 3), write, 1'b1);
      check($sformatf("v1_hold_ready_n%0d", k + 3), in_ready, 1'b0);
    end
    tick();
    check("v1_write_off", write, 1'b0);
    check("v1_busy_off", busy, 1'b0);
    check("v1_ready_on", in_ready, 1'b1);
    check_outputs("v1_after");

    // V4: junk bytes, a truncated frame, then a stall
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    check("v4_junk_busy", busy, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7), 1'b0);
    check("v4_busy_payload", busy, 1'b1);
    repeat (TIMEOUT_C - 10) tick();
    check("v4_busy_pre_to", busy, 1'b1);
    repeat (12) tick();
    check("v4_busy_post_to", busy, 1'b0);
    check("v4_err_cs", err_checksum, 1'b0);
    check("v4_err_rg", err_range, 1'b0);
    check_outputs("v4_to");

    // Full frame after the timeout, with boundary values and embedded 0xA5
    fw = '{32'd1, 32'd2047, 32'h1A5, 32'd100, 32'd200, 32'd300,
           32'd0, 32'd256, 32'hA5, 32'd1, 32'd2, 32'd3, 32'd128};
    send_frame(8'h00, 1'b0);
    repeat (2) tick();
    commit_expect();
    check_outputs("v4_commit");
    check("v4_frames", frames_ok, exp_frames);
    repeat (6) tick();

    // V5: reset on the second HOLD cycle
    fw = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60,
           32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    send_frame(8'h00, 1'b0);
    repeat (2) tick();
    commit_expect();
    check_outputs("v5_commit");
    tick();
    check("v5_write_hold2", write, 1'b1);
    check("v5_ready_hold2", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    check("v5_write", write, 1'b0);
    check("v5_ready", in_ready, 1'b1);
    check("v5_busy", busy, 1'b0);
    check("v5_frames", frames_ok, 8'd0);
    check_outputs("v5_rst");

    // V6: 256 frames with random in_valid gaps
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 6; i++) fw[i] = 32'(1 + ((k * 37 + i * 101) % 2047));
      for (int i = 0; i < 7; i++) fw[6+i] = 32'((k * 13 + i * 7) % 257);
      send_frame(8'h00, 1'b1);
      repeat (2) tick();
      commit_expect();
      check_outputs($sformatf("v6_f%0d", k));
      check($sformatf("v6_f%0d_frames", k), frames_ok, exp_frames);
      repeat (5) tick();
    end
    check("v6_wrap", frames_ok, 8'd0);
    check("v6_err_cs", err_checksum, 1'b0);
    check("v6_err_rg", err_range, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reverb_config_loader.md
REVERB_CONFIG_LOADER -- requirements
Module: reverb_config_loader

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 24, integer part width of each config word
  FRAC, `FIXED_POINT, fractional bits; word width W = WIDTH+FRAC
  MAXDELAY, `MAX_FILTER_FIFO_LENGTH, exclusive upper bound on tau
  TIMEOUT, 1024, maximum idle cycles between bytes inside a frame
  WRITE_HOLD, 4, number of cycles the write output stays high
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single system clock; all logic on its rising edge
  rst  in  1  synchronous reset, active-high
  in_valid  in  1  byte stream valid
  in_data  in  8  byte stream data
  in_ready  out  1  byte accepted when in_valid && in_ready
  tau[6]  out  W signed  delay words: comb0-3, then allpass0-1
  gain[7]  out  W signed  gain words: comb0-3, allpass0-1, output mix
  write  out  1  config-update strobe for the reverberator
  busy  out  1  high in any state except IDLE
  err_checksum  out  1  sticky: last rejected frame had a bad checksum
  err_range  out  1  sticky: last rejected frame had an out-of-range word
  frames_ok  out  8  count of committed frames, wraps 255->0

Function
REQ-003 Frame format SHALL be: header 0xA5; 13 words (tau0..tau5, gain0..gain6), each B = ceil(W/8) bytes, little-endian, upper bits beyond W discarded; checksum byte = XOR of all 13*B payload bytes.
REQ-004 The FSM SHALL have states IDLE, PAYLOAD, CHECK, COMMIT, HOLD.
REQ-005 IDLE: in_ready=1; bytes other than 0xA5 are discarded; 0xA5 -> PAYLOAD with byte counter=0, running XOR=0.
REQ-006 PAYLOAD: in_ready=1; each byte goes into a shadow register array (never the outputs) and is XORed into the running checksum; after 13*B payload bytes the next accepted byte is the checksum, and accepting it -> CHECK.
REQ-007 A 0xA5 byte inside PAYLOAD SHALL be treated as data, not as a resync.
REQ-008 PAYLOAD SHALL count cycles since the last accepted byte; reaching TIMEOUT -> IDLE, shadow discarded, no error flag changes.
REQ-009 CHECK (1 cycle, in_ready=0): checksum mismatch sets err_checksum; else any tau outside [1, MAXDELAY-1] or any gain outside [0, 1<<FRAC] sets err_range; either -> IDLE, outputs unchanged; else -> COMMIT.
REQ-010 Checksum error SHALL take precedence; only one error flag SHALL be set per rejected frame, and the other SHALL be cleared.
REQ-011 COMMIT (1 cycle, in_ready=0): all 13 outputs load from shadow simultaneously; frames_ok increments; both error flags clear; -> HOLD.
REQ-012 HOLD (in_ready=0): write=1 for exactly WRITE_HOLD cycles starting the cycle after COMMIT, then -> IDLE with write=0.
REQ-013 tau/gain SHALL be stable from COMMIT through the next COMMIT; write SHALL rise at least one cycle after the outputs change.
REQ-014 Latency: checksum byte accepted at edge N -> outputs updated at edge N+2, write high from edge N+3 through edge N+2+WRITE_HOLD.
REQ-015 in_ready SHALL be a registered function of state only, not of in_valid.
REQ-016 Range checks SHALL use signed compares on the full W-bit value; negative words are out of range.

Reset
REQ-017 rst high at any edge, including mid-frame or in HOLD, SHALL force IDLE with in_ready=1 on the next cycle, and drop write within that cycle.
REQ-018 Reset values: tau[i]=1, gain[i]=0, write=0, busy=0, err flags=0, frames_ok=0, counters and shadow cleared.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  V1 valid frame (W=32, B=4, 54 bytes), tau={1557,1617,1491,1422,225,556}, gain0-5=0x00B3, gain6=0x00B3 -> outputs match at N+2, write high 4 cycles from N+3, frames_ok=1.
  V2 same frame with checksum^0x01 -> err_checksum=1, outputs still reset values, write stays 0.
  V3 gain2=0x0101 (FRAC=8, >1.0), valid checksum -> err_range=1, no commit; next valid frame -> commit, both flags 0.
  V4 bytes 0x00,0x13 then 20 payload bytes, then a stall of TIMEOUT cycles -> busy falls, no flags; a full valid frame afterwards commits.
  V5 rst asserted on the second HOLD cycle -> write 0 next cycle, outputs back to tau=1/gain=0, frames_ok=0.
  V6 in_valid toggled randomly across a valid frame; 256 consecutive frames -> frames_ok wraps to 0, and data matches on every commit.
